seq_restoring_divider: RTL and testbench
========================================

// Module: seq_restoring_divider
// PURPOSE
//  Multi-cycle unsigned N-bit divider: quotient = dividend / divisor, remainder = dividend % divisor.
//  Restoring algorithm, one quotient bit per clock, built on a ripple subtractor made of FA cells.
//  This is the inverse datapath to our ripple adder; it serves the counter/arithmetic datapaths.
//  Synthesizes to the Actel library.
//  Start/done handshake to a single requester.
// PARAMETERS
//  N   8   operand width; quotient and remainder are also N bits; N >= 2
// PORTS
//  clk           in   1  single clock, rising edge
//  rst_n         in   1  asynchronous, active-low reset
//  start         in   1  request; sampled only while ready=1
//  dividend      in   N  unsigned; captured on accepting edge
//  divisor       in   N  unsigned; captured on accepting edge
//  ready         out  1  high in IDLE and DONE (can accept start)
//  done          out  1  one-cycle pulse; results valid from this cycle
//  quotient      out  N  held until the next accepted start
//  remainder     out  N  held until the next accepted start
//  div_by_zero   out  1  set with done when divisor==0; held like the results
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; ready=1; done=0; quotient=0; remainder=0; div_by_zero=0; step counter=0.
//  FSM states:
//   - IDLE -> CALC when start & divisor!=0.
//   - IDLE -> DONE when start & divisor==0.
//   - CALC -> DONE after the N-th iteration.
//   - DONE -> CALC or DONE on start (same rules as IDLE); DONE -> IDLE otherwise.
//  Accept edge:
//   - Load Q=dividend, D=divisor, R=0 (N+1 bits), cnt=0; clear div_by_zero.
//  CALC, one edge per bit:
//   - R' = {R[N-1:0], Q[N-1]}.
//   - T = R' - {1'b0, D} via the (N+1)-bit subtractor.
//   - If no borrow (sub cout=1): R=T and shift 1 into Q LSB.
//   - Else: R=R' and shift 0 into Q LSB.
//   - cnt++ each iteration; the N-th edge moves to DONE.
//  Latency: done=1 exactly N cycles after the accepting edge (N=8 -> 8).
//  DONE (one cycle):
//   - done=1; quotient=Q; remainder=R[N-1:0].
//   - done drops next cycle unless a new divide completes there.
//  Divide by zero: done 1 cycle after accept; quotient={N{1'b1}}; remainder=dividend; div_by_zero=1.
//  start while in CALC (ready=0): ignored, no effect on state or operands.
//  Operand inputs may change after the accepting edge without effect.
//  Back-to-back: start during DONE is accepted; the next done follows N cycles later.
//  Reset mid-CALC: immediate abort to the reset values; no done is produced.
//  Width rules: R is N+1 bits, so R' cannot overflow; results are never truncated.
// STRUCTURE
//  Shared header div_defs.vh holds:
//   - state encodings IDLE/CALC/DONE (2-bit localparams);
//   - counter width CNT_W = clog2(N+1).
//  One sub-module: cnt_subtractor #(W) — ripple chain of FA cells computing a - b.
//   - b is inverted and cin=1; the final cout is "no borrow" (a >= b).
//   - Instantiated once with W=N+1.
//  Top module: FSM, step counter, R/Q/D registers and output registers only.
// TESTING
//  1) N=8: 100/7 -> quotient=14, remainder=2, div_by_zero=0; done exactly 8 cycles after accept.
//  2) 255/1 -> q=255, r=0; 5/9 -> q=0, r=5; 200/200 -> q=1, r=0.
//  3) 37/0 -> done 1 cycle after accept; q=0xFF, r=37, div_by_zero=1; next 9/3 clears it.
//  4) Pulse start with 50/3 at CALC cycle 3 during 100/7 -> ignored; result is still 14 r 2.
//  5) Drop rst_n at CALC cycle 4 -> outputs zero at once, no done pulse; 60/8 afterwards -> 7 r 4.
//  6) Start 81/9 in the done cycle of 100/7 -> done again 8 cycles later with q=9, r=0.
//  Also: random sweep against a reference model for N=8 and N=4.

Source files
------------

// File: rtl/seq_restoring_divider_pkg.sv
`default_nettype none
//============================================================================
// Module      : seq_restoring_divider_pkg
// Description : Shared definitions for the sequential restoring divider:
//               FSM state encoding and step-counter width helper.
// Revision    : 1.0 - initial release
//============================================================================
package seq_restoring_divider_pkg;

    // Explicit 2-bit encoding; the value 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Step counter must hold 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : seq_restoring_divider_pkg
`default_nettype wire

// File: rtl/seq_restoring_divider_cnt_subtractor.sv
`default_nettype none
//============================================================================
// Module      : cnt_subtractor
// Description : W-bit ripple subtractor diff = a - b built from full-adder
//               cells: b is inverted and the carry-in is tied to 1, so the
//               final carry-out is the "no borrow" flag (a >= b).
// Ports       : a, b  [W-1:0] in  - minuend, subtrahend (unsigned)
//               diff  [W-1:0] out - a - b modulo 2^W
//               cout          out - 1 when a >= b
// Revision    : 1.0 - initial release
//============================================================================
module cnt_subtractor #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         cout
);

    logic [W:0] w_c;

    assign w_c[0] = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_fa
        logic w_nb;
        assign w_nb     = ~b[i];
        assign diff[i]  = a[i] ^ w_nb ^ w_c[i];
        assign w_c[i+1] = (a[i] & w_nb) | (a[i] & w_c[i]) | (w_nb & w_c[i]);
    end

    assign cout = w_c[W];

endmodule : cnt_subtractor
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
//============================================================================
// Module      : seq_restoring_divider
// Description : Multi-cycle unsigned N-bit restoring divider, one quotient
//               bit per clock, with a start/done handshake.
// Ports       : clk, rst_n             - clock, async active-low reset
//               start                  - request, sampled while ready=1
//               dividend, divisor [N]  - operands, captured on accept
//               ready                  - high in IDLE and DONE
//               done                   - one-cycle result pulse
//               quotient, remainder[N] - results, held between divides
//               div_by_zero            - set with done when divisor==0
// Revision    : 1.0 - initial release
//============================================================================
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_q;
    logic [N-1:0]     r_r;
    logic [N-1:0]     r_d;
    logic             r_ready;
    logic             r_done;
    logic [N-1:0]     r_quot;
    logic [N-1:0]     r_rem;
    logic             r_dbz;

    logic [N:0]       w_rshift;
    logic [N:0]       w_diff;
    logic             w_nob;
    logic [N-1:0]     w_rnext;
    logic [N-1:0]     w_qnext;
    logic             w_unused;

    // The partial remainder is always < D after a restoring step, so its
    // (N+1)-th bit is zero between iterations and only N bits are stored.
    // The shifted value R' still carries the full N+1 bits.
    assign w_rshift = {r_r, r_q[N-1]};

    cnt_subtractor #(
        .W (N + 1)
    ) u_sub (
        .a    (w_rshift),
        .b    ({1'b0, r_d}),
        .diff (w_diff),
        .cout (w_nob)
    );

    // When no borrow occurs the difference is < D, so its top bit is zero.
    assign w_unused = w_diff[N];
    assign w_rnext  = w_nob ? w_diff[N-1:0] : w_rshift[N-1:0];
    assign w_qnext  = {r_q[N-2:0], w_nob};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_d     <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    if (start) begin
                        r_q   <= dividend;
                        r_d   <= divisor;
                        r_r   <= '0;
                        r_cnt <= '0;
                        r_dbz <= 1'b0;
                        if (divisor == '0) begin
                            // Result is known immediately; skip CALC.
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_quot  <= '1;
                            r_rem   <= dividend;
                            r_dbz   <= 1'b1;
                        end else begin
                            r_state <= ST_CALC;
                            r_ready <= 1'b0;
                        end
                    end
                end
                ST_CALC: begin
                    r_q   <= w_qnext;
                    r_r   <= w_rnext;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= ST_DONE;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                        r_quot  <= w_qnext;
                        r_rem   <= w_rnext;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready       = r_ready;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule : seq_restoring_divider
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
//============================================================================
// Module      : tb_seq_restoring_divider
// Description : Self-checking bench for seq_restoring_divider (N=8 and N=4).
//               Latency is counted in rising edges after the accepting edge.
// Revision    : 1.0 - initial release
//============================================================================
module tb_seq_restoring_divider;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, ready8, done8, z8;
    logic [7:0] dvd8, dvs8, q8, r8;
    logic       start4, ready4, done4, z4;
    logic [3:0] dvd4, dvs4, q4, r4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.N(8)) dut8 (
        .clk (clk), .rst_n (rst_n), .start (start8),
        .dividend (dvd8), .divisor (dvs8), .ready (ready8), .done (done8),
        .quotient (q8), .remainder (r8), .div_by_zero (z8)
    );

    seq_restoring_divider #(.N(4)) dut4 (
        .clk (clk), .rst_n (rst_n), .start (start4),
        .dividend (dvd4), .divisor (dvs4), .ready (ready4), .done (done4),
        .quotient (q4), .remainder (r4), .div_by_zero (z4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Wait for ready, present operands for one accepting edge, then scramble inputs.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        while (!ready8 && n < 40) begin @(posedge clk); #1; n++; end
        check("ready_before_start", ready8, 1);
        start8 = 1'b1; dvd8 = a; dvs8 = b;
        @(posedge clk); #1;
        start8 = 1'b0; dvd8 = 8'($urandom); dvs8 = 8'($urandom);
    endtask

    task automatic wait8(output int lat);
        lat = 0;
        while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
        check("done_seen_within_bound", done8, 1);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, output int lat);
        int n = 0;
        while (!ready4 && n < 40) begin @(posedge clk); #1; n++; end
        start4 = 1'b1; dvd4 = a; dvs4 = b;
        @(posedge clk); #1;
        start4 = 1'b0; dvd4 = 4'($urandom); dvs4 = 4'($urandom);
        lat = 0;
        while (!done4 && lat < 40) begin @(posedge clk); #1; lat++; end
        check("n4_done_seen_within_bound", done4, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        int   lat, cnt;
        logic [7:0] a, b, eq, er;
        logic [3:0] a4, b4, eq4, er4;
        logic       ez;

        tbl[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 8};
        tbl[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 8};
        tbl[2] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 8};
        tbl[3] = '{8'd200, 8'd200, 8'd1,   8'd0,  1'b0, 8};
        tbl[4] = '{8'd37,  8'd0,   8'd255, 8'd37, 1'b1, 0};
        tbl[5] = '{8'd9,   8'd3,   8'd3,   8'd0,  1'b0, 8};
        tbl[6] = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 8};
        tbl[7] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 8};
        tbl[8] = '{8'd0,   8'd0,   8'd255, 8'd0,  1'b1, 0};
        tbl[9] = '{8'd254, 8'd16,  8'd15,  8'd14, 1'b0, 8};

        rst_n = 1'b0;
        start8 = 1'b0; dvd8 = '0; dvs8 = '0;
        start4 = 1'b0; dvd4 = '0; dvs4 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready",  ready8, 1);
        check("reset_done",   done8,  0);
        check("reset_q",      q8,     0);
        check("reset_r",      r8,     0);
        check("reset_dbz",    z8,     0);
        check("reset_ready4", ready4, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table, including divide-by-zero followed by a clearing divide.
        for (int i = 0; i < 10; i++) begin
            issue8(tbl[i].a, tbl[i].b);
            wait8(lat);
            check($sformatf("tbl%0d_latency", i), lat,      tbl[i].lat);
            check($sformatf("tbl%0d_q", i),       q8,       tbl[i].q);
            check($sformatf("tbl%0d_r", i),       r8,       tbl[i].r);
            check($sformatf("tbl%0d_dbz", i),     z8,       tbl[i].z);
            @(posedge clk); #1;
            check($sformatf("tbl%0d_done_pulse_drops", i), done8, 0);
            check($sformatf("tbl%0d_q_held", i),           q8,    tbl[i].q);
        end

        // start during CALC is ignored.
        issue8(8'd100, 8'd7);
        repeat (3) begin @(posedge clk); #1; end
        start8 = 1'b1; dvd8 = 8'd50; dvs8 = 8'd3;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("busy_ready_low", ready8, 0);
        wait8(lat);
        check("busy_latency", lat + 4, 8);
        check("busy_q", q8, 14);
        check("busy_r", r8, 2);

        // Reset mid-CALC aborts immediately without a done pulse.
        issue8(8'd100, 8'd7);
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("abort_q",     q8,     0);
        check("abort_r",     r8,     0);
        check("abort_dbz",   z8,     0);
        check("abort_done",  done8,  0);
        check("abort_ready", ready8, 1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8) cnt++;
        end
        check("abort_no_done", cnt, 0);
        issue8(8'd60, 8'd8);
        wait8(lat);
        check("post_abort_latency", lat, 8);
        check("post_abort_q", q8, 7);
        check("post_abort_r", r8, 4);

        // Back-to-back: new start presented in the done cycle.
        issue8(8'd100, 8'd7);
        wait8(lat);
        check("b2b_first_q", q8, 14);
        start8 = 1'b1; dvd8 = 8'd81; dvs8 = 8'd9;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("b2b_accepted", ready8, 0);
        wait8(lat);
        check("b2b_latency", lat, 8);
        check("b2b_q", q8, 9);
        check("b2b_r", r8, 0);

        // Random sweep against a plain-arithmetic model, N=8.
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if (b == 0) begin eq = 8'hFF; er = a; ez = 1'b1; end
            else        begin eq = a / b; er = a % b; ez = 1'b0; end
            issue8(a, b);
            wait8(lat);
            check("rnd8_latency", lat, (b == 0) ? 0 : 8);
            check("rnd8_q", q8, eq);
            check("rnd8_r", r8, er);
            check("rnd8_dbz", z8, ez);
        end

        // Random sweep, N=4.
        for (int i = 0; i < 30; i++) begin
            a4 = 4'($urandom_range(0, 15));
            b4 = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            if (b4 == 0) begin eq4 = 4'hF; er4 = a4; ez = 1'b1; end
            else         begin eq4 = a4 / b4; er4 = a4 % b4; ez = 1'b0; end
            op4(a4, b4, lat);
            check("rnd4_latency", lat, (b4 == 0) ? 0 : 4);
            check("rnd4_q", q4, eq4);
            check("rnd4_r", r4, er4);
            check("rnd4_dbz", z4, ez);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_restoring_divider
`default_nettype wire
